// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem request/ack handshake and holds the F->D latch.
// Define FETCH_PERF_CNT_EN to add the perf_fetched_o / perf_bubbles_o counters.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            latch_en_f_i,
  input  logic            pc_redirect_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic            valid_d_o,
  output logic            fetch_busy_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_bubbles_o
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetchState_e;

  fetchState_e     state_q, state_d;
  logic [XLEN-1:0] pcF_q, pcF_d;
  logic [XLEN-1:0] dropAddr_q, dropAddr_d;
  logic [XLEN-1:0] holdInstr_q, holdInstr_d;
  logic [XLEN-1:0] holdPc_q, holdPc_d;
  logic [XLEN-1:0] instrD_q, instrD_d;
  logic [XLEN-1:0] pcD_q, pcD_d;
  logic            validD_q, validD_d;
  logic            loadValid, loadBubble;
  logic [XLEN-1:0] targetAligned;
  logic [XLEN-1:0] pcPlus4;
  logic [1:0]      unusedTargetBits;

  assign targetAligned    = {pc_target_i[XLEN-1:2], 2'b00};
  assign unusedTargetBits = pc_target_i[1:0];
  assign pcPlus4          = pcF_q + XLEN'(4);

  // DROP keeps presenting the abandoned address until memory finally acks it.
  assign imem_req_o   = (state_q != HOLD);
  assign imem_addr_o  = (state_q == DROP) ? dropAddr_q : pcF_q;
  assign fetch_busy_o = imem_req_o && !imem_ack_i;

  assign instr_d_o = instrD_q;
  assign pc_d_o    = pcD_q;
  assign valid_d_o = validD_q;

  always_comb begin
    state_d     = state_q;
    pcF_d       = pcF_q;
    dropAddr_d  = dropAddr_q;
    holdInstr_d = holdInstr_q;
    holdPc_d    = holdPc_q;
    instrD_d    = instrD_q;
    pcD_d       = pcD_q;
    validD_d    = validD_q;
    loadValid   = 1'b0;
    loadBubble  = 1'b0;

    if (pc_redirect_i) begin
      // Redirect wins over stalls; an unacked request must still be drained.
      pcF_d      = targetAligned;
      loadBubble = 1'b1;
      pcD_d      = pcF_q;
      unique case (state_q)
        FETCH: begin
          state_d    = imem_ack_i ? FETCH : DROP;
          dropAddr_d = pcF_q;
        end
        HOLD:    state_d = FETCH;
        default: state_d = DROP;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack_i) begin
            if (latch_en_f_i) begin
              loadValid = 1'b1;
              instrD_d  = imem_rdata_i;
              pcD_d     = pcF_q;
              pcF_d     = pcPlus4;
            end else begin
              holdInstr_d = imem_rdata_i;
              holdPc_d    = pcF_q;
              state_d     = HOLD;
            end
          end else if (latch_en_f_i) begin
            loadBubble = 1'b1;
            pcD_d      = pcF_q;
          end
        end
        HOLD: begin
          if (latch_en_f_i) begin
            loadValid = 1'b1;
            instrD_d  = holdInstr_q;
            pcD_d     = holdPc_q;
            pcF_d     = pcPlus4;
            state_d   = FETCH;
          end
        end
        default: begin
          if (latch_en_f_i) begin
            loadBubble = 1'b1;
            pcD_d      = pcF_q;
          end
          if (imem_ack_i) begin
            state_d = FETCH;
          end
        end
      endcase
    end

    if (loadBubble) begin
      instrD_d = NOP_INSTR;
      validD_d = 1'b0;
    end else if (loadValid) begin
      validD_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= FETCH;
      pcF_q       <= RESET_PC;
      dropAddr_q  <= '0;
      holdInstr_q <= '0;
      holdPc_q    <= '0;
      instrD_q    <= NOP_INSTR;
      pcD_q       <= '0;
      validD_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcF_q       <= pcF_d;
      dropAddr_q  <= dropAddr_d;
      holdInstr_q <= holdInstr_d;
      holdPc_q    <= holdPc_d;
      instrD_q    <= instrD_d;
      pcD_q       <= pcD_d;
      validD_q    <= validD_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetched_q, perfBubbles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perfFetched_q <= '0;
      perfBubbles_q <= '0;
    end else begin
      if (loadValid)  perfFetched_q <= perfFetched_q + 32'd1;
      if (loadBubble) perfBubbles_q <= perfBubbles_q + 32'd1;
    end
  end

  assign perf_fetched_o = perfFetched_q;
  assign perf_bubbles_o = perfBubbles_q;
`else
  logic unusedLoadFlags;
  assign unusedLoadFlags = loadValid ^ loadBubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default build, no perf counters).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        latchEn;
  logic        redirect;
  logic [31:0] target;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        fetchBusy;

  int assertCount;
  int failCount;

  fetch_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .latch_en_f_i  (latchEn),
    .pc_redirect_i (redirect),
    .pc_target_i   (target),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_ack_i    (imemAck),
    .imem_rdata_i  (imemRdata),
    .instr_d_o     (instrD),
    .pc_d_o        (pcD),
    .valid_d_o     (validD),
    .fetch_busy_o  (fetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dataFor(input logic [31:0] addr);
    return 32'hA5A0_0000 ^ addr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; combinational outputs are then checked 1ns later.
  task automatic applyStimulus(input logic en, input logic redir, input logic [31:0] tgt,
                               input logic ack, input logic [31:0] rdata);
    latchEn   = en;
    redirect  = redir;
    target    = tgt;
    imemAck   = ack;
    imemRdata = rdata;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state and back-to-back fetch with ack tied to req
    doReset();
    #1;
    checkOutput("rst_instr", instrD, NOP);
    checkOutput("rst_pc", pcD, 32'h0);
    checkOutput("rst_valid", {31'b0, validD}, 32'd0);
    checkOutput("rst_req", {31'b0, imemReq}, 32'd1);
    checkOutput("rst_addr", imemAddr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'(4 * i)));
      checkOutput("b2b_addr", imemAddr, 32'(4 * i));
      checkOutput("b2b_busy", {31'b0, fetchBusy}, 32'd0);
      nextCycle();
      checkOutput("b2b_instr", instrD, dataFor(32'(4 * i)));
      checkOutput("b2b_pc", pcD, 32'(4 * i));
      checkOutput("b2b_valid", {31'b0, validD}, 32'd1);
    end

    // Ack latency of three cycles
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wait_busy", {31'b0, fetchBusy}, 32'd1);
      checkOutput("wait_addr", imemAddr, 32'h0);
      nextCycle();
      checkOutput("wait_valid", {31'b0, validD}, 32'd0);
      checkOutput("wait_instr", instrD, NOP);
      checkOutput("wait_pc", pcD, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h0));
    checkOutput("wait_ack_busy", {31'b0, fetchBusy}, 32'd0);
    nextCycle();
    checkOutput("wait_done_valid", {31'b0, validD}, 32'd1);
    checkOutput("wait_done_pc", pcD, 32'h0);
    checkOutput("wait_done_instr", instrD, dataFor(32'h0));

    // Stall: ack for pc 8 while latch_en=0 goes to the hold buffer
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h4));
    checkOutput("stall_pre_addr", imemAddr, 32'h4);
    nextCycle();
    checkOutput("stall_pre_pc", pcD, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, dataFor(32'h8));
    checkOutput("stall_addr", imemAddr, 32'h8);
    nextCycle();
    checkOutput("stall_hold_pc", pcD, 32'h4);
    checkOutput("stall_hold_instr", instrD, dataFor(32'h4));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("stall_req", {31'b0, imemReq}, 32'd0);
    checkOutput("stall_busy", {31'b0, fetchBusy}, 32'd0);
    nextCycle();
    checkOutput("stall_hold_pc2", pcD, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("release_req", {31'b0, imemReq}, 32'd0);
    nextCycle();
    checkOutput("release_pc", pcD, 32'h8);
    checkOutput("release_instr", instrD, dataFor(32'h8));
    checkOutput("release_valid", {31'b0, validD}, 32'd1);

    // Redirect to 0x100 while the pc 12 request is outstanding
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    checkOutput("drop_addr0", imemAddr, 32'hC);
    checkOutput("drop_busy0", {31'b0, fetchBusy}, 32'd1);
    nextCycle();
    checkOutput("drop_valid0", {31'b0, validD}, 32'd0);
    checkOutput("drop_instr0", instrD, NOP);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("drop_addr1", imemAddr, 32'hC);
    checkOutput("drop_req1", {31'b0, imemReq}, 32'd1);
    nextCycle();
    checkOutput("drop_valid1", {31'b0, validD}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'hC));
    checkOutput("drop_addr2", imemAddr, 32'hC);
    nextCycle();
    checkOutput("drop_discard_valid", {31'b0, validD}, 32'd0);
    checkOutput("drop_discard_instr", instrD, NOP);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h100));
    checkOutput("redir_addr", imemAddr, 32'h100);
    nextCycle();
    checkOutput("redir_pc", pcD, 32'h100);
    checkOutput("redir_valid", {31'b0, validD}, 32'd1);

    // Redirect with latch_en=0 and ack in the same cycle
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, dataFor(32'h104));
    nextCycle();
    checkOutput("redir_stall_valid", {31'b0, validD}, 32'd0);
    checkOutput("redir_stall_instr", instrD, NOP);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h200));
    checkOutput("redir_stall_addr", imemAddr, 32'h200);
    nextCycle();
    checkOutput("redir_stall_pc", pcD, 32'h200);

    // PC wrap and target alignment
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, dataFor(32'h204));
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'hFFFF_FFFC));
    checkOutput("wrap_addr_top", imemAddr, 32'hFFFF_FFFC);
    nextCycle();
    checkOutput("wrap_pc_top", pcD, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, dataFor(32'h0));
    checkOutput("wrap_addr_zero", imemAddr, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h100));
    checkOutput("align_addr", imemAddr, 32'h100);
    nextCycle();
    checkOutput("align_pc", pcD, 32'h100);

    // Redirect out of HOLD drops the buffered instruction
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, dataFor(32'h104));
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    checkOutput("hold_redir_req", {31'b0, imemReq}, 32'd0);
    nextCycle();
    checkOutput("hold_redir_valid", {31'b0, validD}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, dataFor(32'h300));
    checkOutput("hold_redir_addr", imemAddr, 32'h300);
    nextCycle();
    checkOutput("hold_redir_pc", pcD, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
